icache_ctrl_nway: RTL

Parametrised successor to the 2-way I-cache controller. It controls an N-way set-associative L1 instruction cache with synchronous tag/data RAMs (1-cycle read latency) and sits between IF stage, L1 arrays and L2 cache. Beyond the 2-way block it adds configurable ways, block size and index depth, internal per-set tree-PLRU replacement, pipelined hits (1 fetch/cycle) and a whole-cache flush walker.

---
 rtl/icache_ctrl_nway.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module   : icache_ctrl_nway
// Purpose  : Controller for an N-way set-associative L1 instruction cache with
//            synchronous tag/data RAMs (1-cycle read latency). Pipelined hits
//            at one fetch per cycle, per-set tree-PLRU replacement, L2 refill
//            on miss and a whole-cache flush walker.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_en, if_addr      fetch request and word address from IF
//   flush               invalidate-all request (level)
//   cpu_data, data_rdy  fetched instruction and its valid strobe
//   miss_stall          IF must hold if_addr/if_en
//   flush_busy          flush walk in progress
//   index, block_re     L1 RAM set address and read enable (all ways)
//   tag_rd, data_rd     per-way tag entries {valid,tag} and data blocks
//   way_we              per-way write enable
//   tag_wd, data_wd     tag entry / data block write data
//   irq, l2_addr        L2 refill request and block address {tag,index}
//   l2_rdy, l2_data     L2 refill strobe (1-cycle pulse) and block
// ============================================================================
module icache_ctrl_nway #(
    parameter  int ADDR_W   = 30,
    parameter  int WAYS     = 2,
    parameter  int INDEX_W  = 8,
    parameter  int OFFSET_W = 2,
    parameter  int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    localparam int BLK_W    = 32 << OFFSET_W,
    localparam int TE_W     = TAG_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_en,
    input  logic [ADDR_W-1:0]          if_addr,
    input  logic                       flush,
    output logic [31:0]                cpu_data,
    output logic                       data_rdy,
    output logic                       miss_stall,
    output logic                       flush_busy,
    output logic [INDEX_W-1:0]         index,
    output logic                       block_re,
    input  logic [WAYS*TE_W-1:0]       tag_rd,
    input  logic [WAYS*BLK_W-1:0]      data_rd,
    output logic [WAYS-1:0]            way_we,
    output logic [TAG_W:0]             tag_wd,
    output logic [BLK_W-1:0]           data_wd,
    output logic                       irq,
    output logic [ADDR_W-OFFSET_W-1:0] l2_addr,
    input  logic                       l2_rdy,
    input  logic [BLK_W-1:0]           l2_data
);

    localparam int                 WAY_W    = $clog2(WAYS);
    localparam int                 SETS     = 1 << INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_SET = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_MISS   = 3'd2,
        S_FILL   = 3'd3,
        S_RESP   = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    state_t                    state;
    logic                      req_valid;
    logic [ADDR_W-1:0]         req_addr;
    logic [WAY_W-1:0]          victim;
    logic [BLK_W-1:0]          refill_buf;
    logic [INDEX_W-1:0]        flush_cnt;

    // Tree-PLRU: node n (heap numbering, root = 1) is stored at bit n-1.
    // A node bit of 0 points the victim into the lower-numbered half.
    logic [WAYS-2:0]           plru [SETS];

    logic [TAG_W-1:0]          req_tag;
    logic [INDEX_W-1:0]        req_idx;
    logic [OFFSET_W-1:0]       req_off;
    logic [INDEX_W-1:0]        if_idx;
    logic [WAYS-1:0]           hit_vec;
    logic [WAYS-1:0]           valid_vec;
    logic [WAY_W-1:0]          hit_way;
    logic [WAY_W-1:0]          free_way;
    logic [WAYS-2:0]           set_plru;
    logic [BLK_W-1:0]          hit_blk;
    logic                      lookup_hit;
    logic                      lookup_miss;
    logic                      flush_go;

    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr[OFFSET_W +: INDEX_W];
    assign req_off  = req_addr[OFFSET_W-1:0];
    assign if_idx   = if_addr[OFFSET_W +: INDEX_W];
    assign set_plru = plru[req_idx];

    // ------------------------------------------------------------------
    // Per-way tag compare against the request registered last cycle
    // ------------------------------------------------------------------
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TE_W-1:0] entry;
        assign entry        = tag_rd[w*TE_W +: TE_W];
        assign valid_vec[w] = entry[TAG_W];
        assign hit_vec[w]   = entry[TAG_W] && (entry[TAG_W-1:0] == req_tag);
    end

    // Lowest way wins on both the hit and the free-way search
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])    hit_way  = WAY_W'(w);
            if (!valid_vec[w]) free_way = WAY_W'(w);
        end
    end

    assign hit_blk     = data_rd[int'(hit_way)*BLK_W +: BLK_W];
    assign lookup_hit  = (state == S_ACCESS) && req_valid && (|hit_vec);
    assign lookup_miss = (state == S_ACCESS) && req_valid && !(|hit_vec);
    // A flush may not overtake a miss that still has to be refilled
    assign flush_go    = (state == S_ACCESS) && flush && !lookup_miss;

    // Walk from the root following the node bits down to a leaf.
    function automatic logic [WAY_W-1:0] plru_pick(input logic [WAYS-2:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + int'(bits[node-1]);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Make every node on the path to way w point to the opposite half.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] nb;
        int              leaf;
        int              node;
        int              dir;
        nb   = bits;
        leaf = WAYS + int'(w);
        for (int l = 0; l < WAY_W; l++) begin
            node        = leaf >> (WAY_W - l);
            dir         = (leaf >> (WAY_W - l - 1)) & 1;
            nb[node-1]  = (dir == 0);
        end
        return nb;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM with registered request, refill and L2-facing state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            victim     <= '0;
            refill_buf <= '0;
            flush_cnt  <= '0;
            irq        <= 1'b0;
            l2_addr    <= '0;
            flush_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (lookup_miss) begin
                        victim  <= (|(~valid_vec)) ? free_way : plru_pick(set_plru);
                        irq     <= 1'b1;
                        l2_addr <= req_addr[ADDR_W-1:OFFSET_W];
                        state   <= S_MISS;
                    end else if (flush_go) begin
                        req_valid  <= 1'b0;
                        flush_cnt  <= '0;
                        flush_busy <= 1'b1;
                        state      <= S_FLUSH;
                    end else begin
                        req_valid <= if_en;
                        if (if_en) req_addr <= if_addr;
                    end
                end
                S_MISS: begin
                    if (l2_rdy) begin
                        refill_buf <= l2_data;
                        irq        <= 1'b0;
                        state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    // miss_stall is low here, so IF treats its held fetch
                    // as accepted; register it so it is not lost.
                    req_valid <= if_en;
                    if (if_en) req_addr <= if_addr;
                    state <= S_ACCESS;
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == LAST_SET) begin
                        flush_busy <= 1'b0;
                        state      <= S_ACCESS;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Replacement state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru[s] <= '0;
            end
        end else begin
            if (lookup_hit) begin
                plru[req_idx] <= plru_touch(set_plru, hit_way);
            end else if (state == S_FILL) begin
                plru[req_idx] <= plru_touch(set_plru, victim);
            end else if (state == S_FLUSH) begin
                // Every set is visited once, so the array ends up cleared
                plru[flush_cnt] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM, IF and refill outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        index      = '0;
        block_re   = 1'b0;
        way_we     = '0;
        tag_wd     = '0;
        data_wd    = '0;
        data_rdy   = 1'b0;
        cpu_data   = '0;
        miss_stall = 1'b0;
        case (state)
            S_ACCESS: begin
                index      = if_idx;
                block_re   = if_en;
                data_rdy   = lookup_hit;
                miss_stall = lookup_miss || flush_go;
                if (lookup_hit) cpu_data = hit_blk[int'(req_off)*32 +: 32];
            end
            S_MISS: begin
                miss_stall = 1'b1;
            end
            S_FILL: begin
                index      = req_idx;
                way_we     = WAYS'(1) << victim;
                tag_wd     = {1'b1, req_tag};
                data_wd    = refill_buf;
                miss_stall = 1'b1;
            end
            S_RESP: begin
                index    = if_idx;
                block_re = if_en;
                data_rdy = 1'b1;
                cpu_data = refill_buf[int'(req_off)*32 +: 32];
            end
            S_FLUSH: begin
                index      = flush_cnt;
                way_we     = '1;
                miss_stall = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
